// File: rtl/fc_cmd_arbiter.sv
// Round-robin arbiter sharing one flash controller command port between two requesters.
// Tracks each granted command through accept and completion, with an accept watchdog.
module fc_cmd_arbiter #(
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned TO_W    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [32:0] cmd0,
    input  logic [32:0] cmd1,
    output logic [1:0]  gnt,
    output logic [1:0]  cmp,
    output logic        cmp_err,
    output logic        busy,
    output logic        owner,
    output logic [32:0] fc_cmd,
    output logic        fc_cmd_valid,
    input  logic        fc_done
);

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StComplete} state_e;

    state_e          state_q, state_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            last_q, last_d;
    logic [1:0]      gnt_d, cmp_d;
    logic            cmp_err_d, busy_d, owner_d, valid_d;
    logic [32:0]     fc_cmd_d;
    logic            winner;
    logic [32:0]     win_cmd;

    // On a tie, the requester that did not win last time gets the port.
    always_comb begin
        if (req == 2'b11) begin
            winner = ~last_q;
        end else begin
            winner = req[1];
        end
        win_cmd = winner ? cmd1 : cmd0;
    end

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        err_d     = err_q;
        last_d    = last_q;
        gnt_d     = 2'b00;
        cmp_d     = 2'b00;
        cmp_err_d = 1'b0;
        owner_d   = owner;
        valid_d   = fc_cmd_valid;
        fc_cmd_d  = fc_cmd;

        unique case (state_q)
            StIdle: begin
                if ((req != 2'b00) && fc_done) begin
                    gnt_d    = winner ? 2'b10 : 2'b01;
                    owner_d  = winner;
                    fc_cmd_d = win_cmd;
                    wd_d     = '0;
                    // Zero-length commands never reach the controller.
                    if (win_cmd[6:0] != 7'd0) begin
                        valid_d = 1'b1;
                        state_d = StIssue;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StComplete;
                    end
                end
            end
            StIssue: begin
                if (!fc_done) begin
                    valid_d = 1'b0;
                    wd_d    = '0;
                    state_d = StBusy;
                end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
                    valid_d = 1'b0;
                    wd_d    = '0;
                    err_d   = 1'b1;
                    state_d = StComplete;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StBusy: begin
                if (fc_done) begin
                    err_d   = 1'b0;
                    state_d = StComplete;
                end
            end
            StComplete: begin
                cmp_d     = owner ? 2'b10 : 2'b01;
                cmp_err_d = err_q;
                last_d    = owner;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            wd_q         <= '0;
            err_q        <= 1'b0;
            last_q       <= 1'b1;
            gnt          <= 2'b00;
            cmp          <= 2'b00;
            cmp_err      <= 1'b0;
            busy         <= 1'b0;
            owner        <= 1'b0;
            fc_cmd       <= '0;
            fc_cmd_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            err_q        <= err_d;
            last_q       <= last_d;
            gnt          <= gnt_d;
            cmp          <= cmp_d;
            cmp_err      <= cmp_err_d;
            busy         <= busy_d;
            owner        <= owner_d;
            fc_cmd       <= fc_cmd_d;
            fc_cmd_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_fc_cmd_arbiter.sv
// Bench for fc_cmd_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fc_cmd_arbiter;

    localparam int TB_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [32:0] cmd0, cmd1;
    logic [1:0]  gnt, cmp;
    logic        cmp_err, busy, owner, fc_cmd_valid, fc_done;
    logic [32:0] fc_cmd;

    fc_cmd_arbiter #(.TIMEOUT(TB_TIMEOUT), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd0(cmd0), .cmd1(cmd1),
        .gnt(gnt), .cmp(cmp), .cmp_err(cmp_err), .busy(busy), .owner(owner),
        .fc_cmd(fc_cmd), .fc_cmd_valid(fc_cmd_valid), .fc_done(fc_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one outstanding operation described by who/what/progress.
    localparam int M_ACCEPT = 0, M_WAITDONE = 1, M_REPORT = 2;
    bit          m_active = 0;
    bit          m_last   = 1;
    bit          m_who    = 0;
    bit          m_err    = 0;
    int          m_stage  = 0;
    int          m_issue_cycles = 0;
    logic [32:0] m_cmd    = '0;
    logic [1:0]  e_gnt = 0, e_cmp = 0;
    logic        e_err = 0, e_busy = 0, e_owner = 0, e_valid = 0;
    logic [32:0] e_fc_cmd = '0;

    task automatic model_step();
        bit who;
        if (!rst) begin
            m_active = 0; m_last = 1; e_gnt = 0; e_cmp = 0; e_err = 0;
            e_busy = 0; e_owner = 0; e_fc_cmd = '0; e_valid = 0;
            return;
        end
        e_gnt = 0; e_cmp = 0; e_err = 0;
        if (!m_active) begin
            if (req != 2'b00 && fc_done) begin
                who = (req == 2'b11) ? !m_last : req[1];
                m_cmd = who ? cmd1 : cmd0;
                m_active = 1; m_who = who; m_issue_cycles = 0;
                e_gnt = who ? 2'b10 : 2'b01;
                e_owner = who;
                e_fc_cmd = m_cmd;
                if (m_cmd[6:0] == 7'd0) begin
                    m_stage = M_REPORT; m_err = 1;
                end else begin
                    m_stage = M_ACCEPT; e_valid = 1;
                end
            end
        end else if (m_stage == M_ACCEPT) begin
            m_issue_cycles++;
            if (!fc_done) begin
                m_stage = M_WAITDONE; e_valid = 0;
            end else if (m_issue_cycles == TB_TIMEOUT) begin
                m_stage = M_REPORT; m_err = 1; e_valid = 0;
            end
        end else if (m_stage == M_WAITDONE) begin
            if (fc_done) begin
                m_stage = M_REPORT; m_err = 0;
            end
        end else begin
            e_cmp = m_who ? 2'b10 : 2'b01;
            e_err = m_err;
            m_last = m_who;
            m_active = 0;
        end
        e_busy = m_active;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("gnt", gnt, e_gnt);
        chk("cmp", cmp, e_cmp);
        chk("cmp_err", cmp_err, e_err);
        chk("busy", busy, e_busy);
        chk("owner", owner, e_owner);
        chk("fc_cmd", fc_cmd, e_fc_cmd);
        chk("fc_cmd_valid", fc_cmd_valid, e_valid);
    end

    logic [1:0] gnt_log[$];
    int         valid_cnt = 0;
    int         cmp_cnt   = 0;

    initial forever begin
        @(negedge clk);
        if (gnt != 2'b00) gnt_log.push_back(gnt);
        if (fc_cmd_valid) valid_cnt++;
        if (cmp != 2'b00) cmp_cnt++;
    end

    task automatic wait_gnt(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 2'b00 && n < 100);
        chk({name, "_gnt_seen"}, 64'(gnt != 2'b00), 64'd1);
    endtask

    task automatic wait_cmp(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cmp == 2'b00 && n < 100);
        chk({name, "_cmp_seen"}, 64'(cmp != 2'b00), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [32:0] rand_cmd();
        logic [32:0] c;
        c = {1'($urandom), $urandom};
        if ($urandom_range(3, 0) == 0) c[6:0] = 7'd0;
        return c;
    endfunction

    logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        int c, g, n;
        rst = 1'b0; req = 2'b00; cmd0 = '0; cmd1 = '0; fc_done = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", fc_cmd_valid, 0);
        chk("rst_fc_cmd", fc_cmd, 0);
        rst = 1'b1;

        // Single read op
        cmd0 = {1'b1, 18'h00010, 7'h00, 7'd16};
        req = 2'b01; valid_cnt = 0;
        wait_gnt("s1");
        chk("s1_gnt", gnt, 2'b01);
        chk("s1_fc_cmd", fc_cmd, {1'b1, 18'h00010, 7'h00, 7'd16});
        chk("s1_valid_rise", fc_cmd_valid, 1);
        req = 2'b00;
        @(negedge clk);
        fc_done = 1'b0;
        repeat (40) @(negedge clk);
        fc_done = 1'b1; c = cyc;
        wait_cmp("s1");
        chk("s1_cmp", cmp, 2'b01);
        chk("s1_cmp_err", cmp_err, 0);
        chk("s1_cmp_latency", cyc - c, 2);
        chk("s1_valid_cycles", valid_cnt, 2);

        // Round robin from reset with both requesting
        do_reset();
        gnt_log.delete();
        cmd0 = {1'b0, 18'h00100, 7'h01, 7'd5};
        cmd1 = {1'b1, 18'h02000, 7'h02, 7'd9};
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_gnt("rr");
            chk("rr_owner", owner, 64'(i % 2));
            if (i == 3) req = 2'b00;
            @(negedge clk);
            fc_done = 1'b0;
            repeat (3) @(negedge clk);
            fc_done = 1'b1;
            wait_cmp("rr");
        end
        repeat (3) @(negedge clk);
        chk("rr_count", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("rr_order", gnt_log[i], rr_exp[i]);

        // Zero-length command from requester 1
        cmd1 = {1'b0, 18'h003ff, 7'h12, 7'd0};
        req = 2'b10; valid_cnt = 0;
        wait_gnt("s3");
        g = cyc;
        chk("s3_gnt", gnt, 2'b10);
        req = 2'b00;
        wait_cmp("s3");
        chk("s3_cmp", cmp, 2'b10);
        chk("s3_cmp_err", cmp_err, 1);
        chk("s3_cmp_latency", cyc - g, 1);
        chk("s3_valid_cycles", valid_cnt, 0);

        // Accept watchdog: controller never drops fc_done
        cmd0 = {1'b1, 18'h00abc, 7'h05, 7'd3};
        req = 2'b01; valid_cnt = 0;
        wait_gnt("s4");
        req = 2'b00;
        wait_cmp("s4");
        chk("s4_cmp", cmp, 2'b01);
        chk("s4_cmp_err", cmp_err, 1);
        chk("s4_valid_cycles", valid_cnt, TB_TIMEOUT);
        chk("s4_busy_idle", busy, 0);

        // Reset while BUSY: silent abort, pointer back to requester 0 winning ties
        cmd1 = {1'b0, 18'h01234, 7'h07, 7'd4};
        req = 2'b10;
        wait_gnt("s5");
        req = 2'b00;
        @(negedge clk);
        fc_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("s5_busy_before", busy, 1);
        n = cmp_cnt;
        #2 rst = 1'b0;
        #1;
        chk("s5_rst_gnt", gnt, 0);
        chk("s5_rst_cmp", cmp, 0);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_owner", owner, 0);
        chk("s5_rst_fc_cmd", fc_cmd, 0);
        chk("s5_rst_valid", fc_cmd_valid, 0);
        fc_done = 1'b1;
        repeat (3) @(negedge clk);
        chk("s5_no_cmp", cmp_cnt, n);
        rst = 1'b1;
        cmd0 = {1'b0, 18'h00020, 7'h03, 7'd2};
        req = 2'b11;
        wait_gnt("s5_post");
        chk("s5_tie_winner", gnt, 2'b01);
        req = 2'b00;
        @(negedge clk);
        fc_done = 1'b0;
        @(negedge clk);
        fc_done = 1'b1;
        wait_cmp("s5_post");

        // Controller busy at request time
        fc_done = 1'b0;
        cmd0 = {1'b1, 18'h00040, 7'h04, 7'd1};
        req = 2'b01;
        n = gnt_log.size();
        repeat (5) @(negedge clk);
        chk("s6_no_gnt", gnt_log.size(), n);
        fc_done = 1'b1; c = cyc;
        wait_gnt("s6");
        chk("s6_gnt_latency", cyc - c, 1);
        req = 2'b00;
        @(negedge clk);
        fc_done = 1'b0;
        @(negedge clk);
        fc_done = 1'b1;
        wait_cmp("s6");

        // Randomized traffic checked by the per-cycle model comparison
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(3, 0) == 0) req = 2'($urandom);
            if ($urandom_range(5, 0) == 0) fc_done = ~fc_done;
            if ($urandom_range(7, 0) == 0) cmd0 = rand_cmd();
            if ($urandom_range(7, 0) == 0) cmd1 = rand_cmd();
        end
        req = 2'b00; fc_done = 1'b1;
        repeat (30) @(negedge clk);
        chk("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/fc_cmd_arbiter.md
Name: fc_cmd_arbiter

Overview:
Shares the single flash controller command port between two requesters (e.g. host DMA and background scrubber) using round-robin arbitration. Captures the winner's 33-bit command and presents it to the controller. Tracks the controller's done handshake through accept and completion, then returns a per-requester completion pulse. Adds an accept watchdog and rejects zero-length commands without touching the flash.

Parameters:
TIMEOUT, 1000, max cycles in ISSUE waiting for fc_done to fall before aborting.
TO_W, 10, width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  reset, asynchronous, active-low
req  in  2  level request per requester; held until matching gnt bit seen
cmd0  in  33  requester 0 command: [32] read(1)/write(0), [31:14] flash addr, [13:7] internal mem addr, [6:0] length
cmd1  in  33  requester 1 command, same format
gnt  out  2  one-cycle pulse: command of that requester captured; requester may drop req/change cmd
cmp  out  2  one-cycle pulse: that requester's command finished
cmp_err  out  1  valid with cmp; 1 = aborted (timeout or zero length)
busy  out  1  1 whenever state != IDLE
owner  out  1  index of requester currently being served (hold last value in IDLE)
fc_cmd  out  33  command to flash controller, stable while fc_cmd_valid
fc_cmd_valid  out  1  command presented to controller
fc_done  in  1  controller done: 1 = idle/accepting, 0 = busy

Behaviour:
- All outputs registered. On rst low, immediately: state IDLE; gnt, cmp, cmp_err, busy, owner, fc_cmd, fc_cmd_valid all 0; watchdog 0; last-grant pointer = 1, so requester 0 wins first tie.
- States: IDLE, ISSUE, BUSY, COMPLETE.
- IDLE:
  - Wait for any req bit and fc_done==1. Winner is the sole requester, or on tie the one not equal to the last-grant pointer.
  - At that edge: capture the winner's cmd into fc_cmd, set owner, and pulse gnt[winner] for one cycle.
  - If cmd[6:0]!=0: set fc_cmd_valid=1 and go to ISSUE.
  - If cmd[6:0]==0: go to COMPLETE with err flag set; fc_cmd_valid stays 0.
  - If fc_done==0 in IDLE, no grant.
- ISSUE:
  - fc_cmd_valid=1 and fc_cmd held constant. Watchdog increments each cycle.
  - fc_done sampled 0: clear valid, clear watchdog, go to BUSY.
  - Watchdog reaches TIMEOUT first: clear valid, go to COMPLETE with err flag.
- BUSY: wait for fc_done sampled 1, then go to COMPLETE with err flag clear.
- COMPLETE, one cycle:
  - cmp[owner]=1 and cmp_err=err flag for exactly this cycle.
  - Update last-grant pointer to owner; go to IDLE.
  - A grant may be issued on the IDLE cycle immediately following.
- Latency for a zero-length command: gnt in cycle N+1, cmp in cycle N+2, where cycle N is the IDLE cycle with req sampled.
- req changes while not in IDLE are ignored until the next IDLE cycle. A req still high after its own cmp is treated as a new request.
- req deasserted before grant: no grant, no cmp.
- Reset during ISSUE or BUSY aborts silently with no cmp. The flash controller is reset independently.
- gnt and cmp are never simultaneously high for different requesters. At most one bit of each is high in any cycle.

Test Plan:
- Single op: req=01, cmd0 = read, addr 0x00010, length 16, fc_done falls 2 cycles after valid and rises 40 cycles later -> gnt=01 one cycle; fc_cmd=cmd0; valid high for exactly 2 cycles; cmp=01 with cmp_err=0 one cycle after done rises.
- Round robin: req=11 held continuously, controller completing each op -> grant order 0,1,0,1; owner toggles; no two gnt bits ever high together.
- Zero length: cmd1[6:0]=0, req=10 -> gnt=10 then next cycle cmp=10 with cmp_err=1; fc_cmd_valid never asserted.
- Timeout: TIMEOUT=8, fc_done held 1 -> valid drops after 8 ISSUE cycles; cmp=owner with cmp_err=1; busy returns to 0.
- Reset mid-BUSY: assert rst low asynchronously -> all outputs 0 without waiting for clk; no cmp; first post-reset tie goes to requester 0.
- Controller busy at request: fc_done=0 while req=01 -> no gnt until fc_done=1 sampled in IDLE.
